// File: rtl/ram_port_arb_pkg.sv
// Shared types and sizing for the two-master RAM port-A arbiter.
package ram_port_arb_pkg;

    localparam int unsigned DEPTH     = 2048;
    localparam int unsigned WIDTH     = 32;
    localparam int unsigned ADDR_BITS = $clog2(DEPTH);
    localparam int unsigned BE_BITS   = WIDTH / 8;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_id_e;

    typedef struct packed {
        logic                 wr;
        logic [ADDR_BITS-1:0] addr;
        logic [BE_BITS-1:0]   be;
        logic [WIDTH-1:0]     wdata;
    } cmd_t;

    // Read accepted last cycle whose ram_q lands this cycle.
    typedef struct packed {
        logic       valid;
        master_id_e id;
    } tag_t;

endpackage

// File: rtl/ram_port_arb_pick.sv
// Two-input grant picker. RAM_PORT_ARB_ROUND_ROBIN_EN selects round-robin on
// contention; otherwise m0 has fixed priority and the pointer is ignored.
module ram_port_arb_pick
    import ram_port_arb_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_e last,
    output logic [1:0] grant
);

`ifdef RAM_PORT_ARB_ROUND_ROBIN_EN
    // On contention favour the master that was not granted last.
    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last == M0) ? 2'b10 : 2'b01;
        end
    end
`else
    logic unused_last;
    assign unused_last = last;

    // Fixed priority: m0 always wins.
    always_comb begin
        grant = 2'b00;
        if (req[0]) begin
            grant = 2'b01;
        end else if (req[1]) begin
            grant = 2'b10;
        end
    end
`endif

endmodule

// File: rtl/ram_port_arb.sv
// Two-master arbiter/sequencer for block RAM port A with per-master read
// response hold registers. Optional macro: RAM_PORT_ARB_ROUND_ROBIN_EN.
module ram_port_arb
    import ram_port_arb_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,

    input  logic                 m0_cmd_valid,
    output logic                 m0_cmd_ready,
    input  logic                 m0_cmd_wr,
    input  logic [ADDR_BITS-1:0] m0_cmd_addr,
    input  logic [BE_BITS-1:0]   m0_cmd_be,
    input  logic [WIDTH-1:0]     m0_cmd_wdata,
    output logic                 m0_rsp_valid,
    input  logic                 m0_rsp_ready,
    output logic [WIDTH-1:0]     m0_rsp_rdata,

    input  logic                 m1_cmd_valid,
    output logic                 m1_cmd_ready,
    input  logic                 m1_cmd_wr,
    input  logic [ADDR_BITS-1:0] m1_cmd_addr,
    input  logic [BE_BITS-1:0]   m1_cmd_be,
    input  logic [WIDTH-1:0]     m1_cmd_wdata,
    output logic                 m1_rsp_valid,
    input  logic                 m1_rsp_ready,
    output logic [WIDTH-1:0]     m1_rsp_rdata,

    output logic [ADDR_BITS-1:0] ram_address,
    output logic                 ram_wren,
    output logic [BE_BITS-1:0]   ram_byteena,
    output logic [WIDTH-1:0]     ram_data,
    input  logic [WIDTH-1:0]     ram_q
);

    cmd_t                 cmd0, cmd1, cmd_sel;
    tag_t                 tag_q, tag_d;
    master_id_e           last_q, last_d, sel_id;
    logic [1:0]           valid, rsp_ready, wr, own, land, elig, req, grant, hold_vis;
    logic [1:0]           hold_valid_q, hold_valid_d;
    logic [1:0][WIDTH-1:0] hold_data_q, hold_data_d, rsp_rdata;
    logic [1:0]           rsp_valid;
    logic                 accept;
    logic [ADDR_BITS-1:0] addr_q;
    logic [BE_BITS-1:0]   be_q;
    logic [WIDTH-1:0]     data_q;

    assign cmd0 = '{wr: m0_cmd_wr, addr: m0_cmd_addr, be: m0_cmd_be, wdata: m0_cmd_wdata};
    assign cmd1 = '{wr: m1_cmd_wr, addr: m1_cmd_addr, be: m1_cmd_be, wdata: m1_cmd_wdata};

    assign valid     = {m1_cmd_valid, m0_cmd_valid};
    assign rsp_ready = {m1_rsp_ready, m0_rsp_ready};
    assign wr        = {m1_cmd_wr, m0_cmd_wr};

    // Own read in flight per master; its data lands this cycle unless in reset.
    assign own[0] = tag_q.valid & (tag_q.id == M0);
    assign own[1] = tag_q.valid & (tag_q.id == M1);
    assign land   = own & ~{2{reset}};

    // Reads need somewhere guaranteed to put their data: empty hold register and
    // either no landing read or a landing read that is consumed this cycle.
    assign elig = wr | (~hold_valid_q & (~own | rsp_ready));
    assign req  = valid & elig & ~{2{reset}};

    ram_port_arb_pick u_pick (
        .req   (req),
        .last  (last_q),
        .grant (grant)
    );

    assign accept       = |grant;
    assign sel_id       = grant[1] ? M1 : M0;
    assign cmd_sel      = grant[1] ? cmd1 : cmd0;
    assign m0_cmd_ready = grant[0];
    assign m1_cmd_ready = grant[1];

    // RAM drive: granted command passes straight through, otherwise hold last values.
    always_comb begin
        ram_wren    = accept & cmd_sel.wr;
        ram_address = addr_q;
        ram_byteena = be_q;
        ram_data    = data_q;
        if (accept) begin
            ram_address = cmd_sel.addr;
            ram_byteena = cmd_sel.be;
            ram_data    = cmd_sel.wdata;
        end
    end

    // Pointer and in-flight tag next state.
    always_comb begin
        last_d      = accept ? sel_id : last_q;
        tag_d.valid = accept & ~cmd_sel.wr;
        tag_d.id    = sel_id;
    end

    // Response steering and hold-register next state per master.
    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        hold_vis     = hold_valid_q & ~{2{reset}};
        for (int i = 0; i < 2; i++) begin
            rsp_valid[i] = hold_vis[i] | land[i];
            rsp_rdata[i] = hold_vis[i] ? hold_data_q[i] : (land[i] ? ram_q : '0);
            if (hold_valid_q[i]) begin
                if (rsp_ready[i]) begin
                    hold_valid_d[i] = 1'b0;
                end
            end else if (land[i] && !rsp_ready[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_data_d[i]  = ram_q;
            end
        end
    end

    assign m0_rsp_valid = rsp_valid[0];
    assign m1_rsp_valid = rsp_valid[1];
    assign m0_rsp_rdata = rsp_rdata[0];
    assign m1_rsp_rdata = rsp_rdata[1];

    // State registers; reset drops any in-flight read and makes m0 win first.
    always_ff @(posedge clock) begin
        if (reset) begin
            tag_q        <= '{valid: 1'b0, id: M0};
            last_q       <= M1;
            hold_valid_q <= '0;
            hold_data_q  <= '0;
            addr_q       <= '0;
            be_q         <= '0;
            data_q       <= '0;
        end else begin
            tag_q        <= tag_d;
            last_q       <= last_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            addr_q       <= ram_address;
            be_q         <= ram_byteena;
            data_q       <= ram_data;
        end
    end

endmodule

// File: tb/tb_ram_port_arb.sv
// Directed self-checking bench for ram_port_arb with a behavioural 1-cycle RAM.
module tb_ram_port_arb;

`ifdef RAM_PORT_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clock, reset;
    logic        m0_cmd_valid, m0_cmd_ready, m0_cmd_wr, m0_rsp_valid, m0_rsp_ready;
    logic [10:0] m0_cmd_addr;
    logic [3:0]  m0_cmd_be;
    logic [31:0] m0_cmd_wdata, m0_rsp_rdata;
    logic        m1_cmd_valid, m1_cmd_ready, m1_cmd_wr, m1_rsp_valid, m1_rsp_ready;
    logic [10:0] m1_cmd_addr;
    logic [3:0]  m1_cmd_be;
    logic [31:0] m1_cmd_wdata, m1_rsp_rdata;
    logic [10:0] ram_address;
    logic        ram_wren;
    logic [3:0]  ram_byteena;
    logic [31:0] ram_data, ram_q;
    logic [31:0] mem [2048];

    int checks = 0;
    int errors = 0;

    ram_port_arb dut (
        .clock        (clock),
        .reset        (reset),
        .m0_cmd_valid (m0_cmd_valid),
        .m0_cmd_ready (m0_cmd_ready),
        .m0_cmd_wr    (m0_cmd_wr),
        .m0_cmd_addr  (m0_cmd_addr),
        .m0_cmd_be    (m0_cmd_be),
        .m0_cmd_wdata (m0_cmd_wdata),
        .m0_rsp_valid (m0_rsp_valid),
        .m0_rsp_ready (m0_rsp_ready),
        .m0_rsp_rdata (m0_rsp_rdata),
        .m1_cmd_valid (m1_cmd_valid),
        .m1_cmd_ready (m1_cmd_ready),
        .m1_cmd_wr    (m1_cmd_wr),
        .m1_cmd_addr  (m1_cmd_addr),
        .m1_cmd_be    (m1_cmd_be),
        .m1_cmd_wdata (m1_cmd_wdata),
        .m1_rsp_valid (m1_rsp_valid),
        .m1_rsp_ready (m1_rsp_ready),
        .m1_rsp_rdata (m1_rsp_rdata),
        .ram_address  (ram_address),
        .ram_wren     (ram_wren),
        .ram_byteena  (ram_byteena),
        .ram_data     (ram_data),
        .ram_q        (ram_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Byte-enabled RAM with registered read; reads see writes from earlier cycles.
    always @(posedge clock) begin
        if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byteena[b]) mem[ram_address][b*8 +: 8] <= ram_data[b*8 +: 8];
            end
        end
        ram_q <= mem[ram_address];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input int m, input bit v, input bit w, input int a,
                         input logic [3:0] be, input logic [31:0] d);
        if (m == 0) begin
            m0_cmd_valid = v; m0_cmd_wr = w; m0_cmd_addr = 11'(a);
            m0_cmd_be = be; m0_cmd_wdata = d;
        end else begin
            m1_cmd_valid = v; m1_cmd_wr = w; m1_cmd_addr = 11'(a);
            m1_cmd_be = be; m1_cmd_wdata = d;
        end
    endtask

    // Single command that must be accepted in its first cycle.
    task automatic one(input string tag, input int m, input bit w, input int a,
                       input logic [3:0] be, input logic [31:0] d);
        drive(m, 1'b1, w, a, be, d);
        @(negedge clock);
        chk(tag, (m == 0) ? m0_cmd_ready : m1_cmd_ready, 1);
        tick();
        drive(m, 1'b0, 1'b0, 0, 4'h0, 32'h0);
    endtask

    initial begin
        bit exp0, exp1, prev0, prev1;
        reset = 1'b1;
        m0_rsp_ready = 1'b1;
        m1_rsp_ready = 1'b1;
        drive(0, 1'b1, 1'b0, 3, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 4, 4'hF, 32'h0);
        #1;
        tick();
        @(negedge clock);
        chk("rst_cmd_ready0", m0_cmd_ready, 0);
        chk("rst_cmd_ready1", m1_cmd_ready, 0);
        tick();
        reset = 1'b0;
        drive(0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        @(negedge clock);
        chk("rst_rsp_valid0", m0_rsp_valid, 0);
        chk("rst_rsp_valid1", m1_rsp_valid, 0);
        chk("rst_wren", ram_wren, 0);
        chk("rst_address", 32'(ram_address), 0);
        chk("rst_byteena", 32'(ram_byteena), 0);
        chk("rst_data", ram_data, 0);
        chk("rst_rdata0", m0_rsp_rdata, 0);
        chk("rst_rdata1", m1_rsp_rdata, 0);
        tick();

        // Single write then read from m0.
        drive(0, 1'b1, 1'b1, 5, 4'hF, 32'hDEADBEEF);
        @(negedge clock);
        chk("wr_ready", m0_cmd_ready, 1);
        chk("wr_wren", ram_wren, 1);
        chk("wr_address", 32'(ram_address), 5);
        chk("wr_data", ram_data, 32'hDEADBEEF);
        tick();
        drive(0, 1'b1, 1'b0, 5, 4'hF, 32'h0);
        @(negedge clock);
        chk("rd_ready", m0_cmd_ready, 1);
        chk("rd_wren", ram_wren, 0);
        tick();
        drive(0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        @(negedge clock);
        chk("rd_rsp_valid0", m0_rsp_valid, 1);
        chk("rd_rdata0", m0_rsp_rdata, 32'hDEADBEEF);
        chk("rd_rsp_valid1", m1_rsp_valid, 0);
        chk("idle_addr_hold", 32'(ram_address), 5);
        tick();
        @(negedge clock);
        chk("rd_rsp_drop0", m0_rsp_valid, 0);
        tick();

        // Byte enables.
        one("be_wr_full", 0, 1'b1, 7, 4'hF, 32'h11223344);
        one("be_wr_part", 0, 1'b1, 7, 4'b0101, 32'hAABBCCDD);
        one("be_rd", 0, 1'b0, 7, 4'h0, 32'h0);
        @(negedge clock);
        chk("be_rdata", m0_rsp_rdata, 32'h11BB33DD);
        tick();

        // Write in N, read same address in N+1 from m1.
        one("wtr_wr", 1, 1'b1, 9, 4'hF, 32'h00000055);
        one("wtr_rd", 1, 1'b0, 9, 4'h0, 32'h0);
        @(negedge clock);
        chk("wtr_rsp_valid1", m1_rsp_valid, 1);
        chk("wtr_rdata1", m1_rsp_rdata, 32'h00000055);
        chk("wtr_rsp_valid0", m0_rsp_valid, 0);
        tick();

        // Contention: both masters read every cycle.
        drive(0, 1'b1, 1'b0, 5, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 9, 4'h0, 32'h0);
        prev0 = 1'b0;
        prev1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            exp0 = RR ? (k % 2 == 0) : 1'b1;
            exp1 = !exp0;
            @(negedge clock);
            chk($sformatf("cont_ready0_%0d", k), m0_cmd_ready, exp0);
            chk($sformatf("cont_ready1_%0d", k), m1_cmd_ready, exp1);
            chk($sformatf("cont_rsp0_%0d", k), m0_rsp_valid, prev0);
            chk($sformatf("cont_rsp1_%0d", k), m1_rsp_valid, prev1);
            prev0 = exp0;
            prev1 = exp1;
            tick();
        end
        drive(0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        @(negedge clock);
        chk("cont_last_rsp0", m0_rsp_valid, prev0);
        chk("cont_last_rsp1", m1_rsp_valid, prev1);
        tick();

        // Backpressure on m1 while m0 keeps being served.
        one("bp_wr1", 0, 1'b1, 1, 4'hF, 32'h000000A1);
        one("bp_wr2", 0, 1'b1, 2, 4'hF, 32'h000000A2);
        m1_rsp_ready = 1'b0;
        one("bp_rd1", 1, 1'b0, 1, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 2, 4'h0, 32'h0);
        drive(0, 1'b1, 1'b0, 9, 4'h0, 32'h0);
        @(negedge clock);
        chk("bp_land_valid", m1_rsp_valid, 1);
        chk("bp_land_rdata", m1_rsp_rdata, 32'h000000A1);
        chk("bp_blk_ready1_a", m1_cmd_ready, 0);
        chk("bp_m0_ready_a", m0_cmd_ready, 1);
        tick();
        drive(0, 1'b1, 1'b0, 5, 4'h0, 32'h0);
        @(negedge clock);
        chk("bp_hold_valid", m1_rsp_valid, 1);
        chk("bp_hold_rdata", m1_rsp_rdata, 32'h000000A1);
        chk("bp_blk_ready1_b", m1_cmd_ready, 0);
        chk("bp_m0_rdata_a", m0_rsp_rdata, 32'h00000055);
        chk("bp_m0_ready_b", m0_cmd_ready, 1);
        tick();
        drive(0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        m1_rsp_ready = 1'b1;
        @(negedge clock);
        chk("bp_release_valid", m1_rsp_valid, 1);
        chk("bp_release_rdata", m1_rsp_rdata, 32'h000000A1);
        chk("bp_blk_ready1_c", m1_cmd_ready, 0);
        chk("bp_m0_rdata_b", m0_rsp_rdata, 32'hDEADBEEF);
        tick();
        @(negedge clock);
        chk("bp_rd2_ready", m1_cmd_ready, 1);
        chk("bp_drop_valid", m1_rsp_valid, 0);
        tick();
        drive(1, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        @(negedge clock);
        chk("bp_rd2_valid", m1_rsp_valid, 1);
        chk("bp_rd2_rdata", m1_rsp_rdata, 32'h000000A2);
        tick();
        @(negedge clock);
        chk("bp_rd2_drop", m1_rsp_valid, 0);
        tick();

        // Reset the cycle after a read is accepted.
        one("rst_mid_rd", 1, 1'b0, 9, 4'h0, 32'h0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_rsp1_a", m1_rsp_valid, 0);
        tick();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_rsp1_b", m1_rsp_valid, 0);
        chk("rst_mid_rsp0", m0_rsp_valid, 0);
        tick();
        drive(0, 1'b1, 1'b0, 5, 4'h0, 32'h0);
        drive(1, 1'b1, 1'b0, 9, 4'h0, 32'h0);
        @(negedge clock);
        chk("post_rst_ready0", m0_cmd_ready, 1);
        chk("post_rst_ready1", m1_cmd_ready, 0);
        tick();
        @(negedge clock);
        chk("post_rst2_ready0", m0_cmd_ready, RR ? 0 : 1);
        chk("post_rst2_ready1", m1_cmd_ready, RR ? 1 : 0);
        tick();
        drive(0, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 0, 4'h0, 32'h0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
